lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter ADDR_W SHALL have default 32 and set the address width of alu_data and mem_addr.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  SHALL be asynchronous, active-high reset.
REQ-004 req_valid  in  1  load/store request from execute stage.
REQ-005 req_ready  out  1  request accepted when req_valid and req_ready are both high.
REQ-006 is_store  in  1  1 = store, 0 = load.
REQ-007 funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 alu_data  in  ADDR_W  effective address from ALU.
REQ-009 store_data  in  32  rs2 value.
REQ-010 mem_req / mem_we  out  1 / 1  memory request, write enable.
REQ-011 mem_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0.
REQ-012 mem_be / mem_wdata  out  4 / 32  byte enables, lane-aligned write data.
REQ-013 mem_gnt / mem_rvalid / mem_rdata  in  1 / 1 / 32  grant, read-data valid, read data.
REQ-014 rsp_valid / load_data / misalign  out  1 / 32 / 1  completion pulse, extended load result, misalignment flag.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 On accept in IDLE, address, funct3, is_store, byte enables and lane-aligned write data SHALL be registered; next state REQ.
REQ-017 In REQ, mem_req SHALL stay high with stable outputs until mem_gnt; on gnt, a store SHALL go to RESP and a load SHALL go to WAIT.
REQ-018 mem_rvalid SHALL be honoured only in WAIT; on it, mem_rdata SHALL be captured and the state SHALL go to RESP.
REQ-019 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; a new request is acceptable in that following cycle.
REQ-020 Minimum latency, accept to rsp_valid: load 3 cycles, store 2 cycles.
REQ-021 Byte enables SHALL be: B 0001<<addr[1:0]; H 0011 (addr[1]=0) or 1100; W 1111.
REQ-022 Write data SHALL be: SB byte replicated ×4; SH halfword replicated ×2; SW unchanged.
REQ-023 Load data SHALL be mem_rdata >> (8·addr[1:0]), then sign-extended (B/H) or zero-extended (BU/HU) from bit 7/15.
REQ-024 Unused funct3 (011, 110, 111) SHALL behave as W.
REQ-025 load_data SHALL hold its value until the next load completes; for stores it SHALL be unchanged.
REQ-026 mem_gnt outside REQ and mem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-027 rst SHALL force IDLE immediately and abandon any in-flight transaction without a response.
REQ-028 While rst is high, all outputs SHALL be 0, req_ready included; req_ready SHALL be 1 the first cycle after release.

Configuration
REQ-029 With MISALIGN_TRAP_EN defined, misaligned H/HU (addr[0]=1) and W (addr[1:0]≠0) SHALL skip REQ/WAIT and go IDLE→RESP with misalign=1, load_data=0, mem_req never asserted.
REQ-030 Without MISALIGN_TRAP_EN, misalign SHALL be tied 0 and misaligned requests SHALL be forced to alignment (H uses addr[1] only, W ignores addr[1:0]).

Structure
REQ-031 Package riscv_pkg SHALL hold the lsu_state_t enum and the funct3 constants F3_LB/LH/LW/LBU/LHU.
REQ-032 Combinational byte-lane, write-data and extension logic SHALL live in the sub-module lsu_align; lsu holds the FSM and registers.

Verification
REQ-033 LW addr 0x100, gnt 1st REQ cycle, rvalid next, rdata 0xDEADBEEF -> mem_addr 0x100, be 1111, rsp_valid 3 cycles after accept, load_data 0xDEADBEEF.
REQ-034 LB addr 0x103, rdata 0x80112233 -> be 1000, load_data 0xFFFFFF80; same request as LBU -> 0x00000080.
REQ-035 SH addr 0x206, store_data 0x0000ABCD, gnt delayed 3 cycles -> mem_req held 4 cycles, be 1100, wdata 0xABCDABCD, mem_we 1, single rsp_valid.
REQ-036 With macro, LW addr 0x102 -> no mem_req, rsp_valid 1 cycle after accept, misalign 1; without macro -> mem_addr 0x100, misalign 0.
REQ-037 Assert rst while in WAIT, then pulse mem_rvalid -> no rsp_valid, req_ready 1 after release, next LW completes normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared types and constants for the load/store unit.
//   lsu_state_t   : LSU transaction FSM states (IDLE, REQ, WAIT, RESP)
//   access_size_t : decoded access width (byte, halfword, word)
//   F3_*          : funct3 encodings for loads/stores
//   f3_size       : funct3 -> access width; unused encodings decode as word
//   f3_unsigned   : funct3 -> zero-extend flag (LBU/LHU)
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Reserved encodings (011, 110, 111) fall through to a word access.
    function automatic access_size_t f3_size(input logic [2:0] f3);
        access_size_t sz;
        case (f3)
            F3_LB, F3_LBU: sz = SZ_BYTE;
            F3_LH, F3_LHU: sz = SZ_HALF;
            default:       sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic f3_unsigned(input logic [2:0] f3);
        return (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align -- purely combinational lane logic for the LSU.
// Request side (live request inputs):
//   req_funct3, req_offset(addr[1:0]), store_data -> req_be, req_wdata,
//   req_lane (byte offset after forced alignment), req_misalign
//   (only ever 1 when TRAP_EN is set).
// Response side (registered request attributes):
//   rsp_funct3, rsp_lane, rdata -> load_ext (shifted, sign/zero extended).
module lsu_align
    import riscv_pkg::*;
#(
    parameter bit TRAP_EN = 1'b0
) (
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_offset,
    input  logic [31:0] store_data,
    output logic [3:0]  req_be,
    output logic [31:0] req_wdata,
    output logic [1:0]  req_lane,
    output logic        req_misalign,
    input  logic [2:0]  rsp_funct3,
    input  logic [1:0]  rsp_lane,
    input  logic [31:0] rdata,
    output logic [31:0] load_ext
);

    access_size_t req_size_s;
    access_size_t rsp_size_s;
    logic         raw_misalign_s;
    logic [31:0]  shifted_s;

    assign req_size_s = f3_size(req_funct3);
    assign rsp_size_s = f3_size(rsp_funct3);

    // Byte enables, replicated write data and the lane actually used.
    // Halfwords keep only addr[1] and words ignore addr[1:0], so a
    // misaligned request that is not trapped lands on an aligned lane.
    always_comb begin
        req_be         = 4'b1111;
        req_wdata      = store_data;
        req_lane       = 2'b00;
        raw_misalign_s = 1'b0;
        case (req_size_s)
            SZ_BYTE: begin
                req_lane  = req_offset;
                req_be    = 4'b0001 << req_offset;
                req_wdata = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                req_lane       = {req_offset[1], 1'b0};
                req_be         = req_offset[1] ? 4'b1100 : 4'b0011;
                req_wdata      = {2{store_data[15:0]}};
                raw_misalign_s = req_offset[0];
            end
            SZ_WORD: begin
                raw_misalign_s = (req_offset != 2'b00);
            end
            default: begin
                raw_misalign_s = (req_offset != 2'b00);
            end
        endcase
        req_misalign = TRAP_EN & raw_misalign_s;
    end

    assign shifted_s = rdata >> {rsp_lane, 3'b000};

    // Extend the shifted read data from bit 7 or bit 15.
    always_comb begin
        load_ext = shifted_s;
        case (rsp_size_s)
            SZ_BYTE: begin
                load_ext = f3_unsigned(rsp_funct3) ? {24'h000000, shifted_s[7:0]}
                                                   : {{24{shifted_s[7]}}, shifted_s[7:0]};
            end
            SZ_HALF: begin
                load_ext = f3_unsigned(rsp_funct3) ? {16'h0000, shifted_s[15:0]}
                                                   : {{16{shifted_s[15]}}, shifted_s[15:0]};
            end
            SZ_WORD: begin
                load_ext = shifted_s;
            end
            default: begin
                load_ext = shifted_s;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu -- single-outstanding load/store unit between execute and a
// request/grant/rvalid data memory port.
// Ports:
//   clk, rst (async, active-high)
//   req_valid/req_ready, is_store, funct3, alu_data, store_data : request
//   mem_req, mem_we, mem_addr (word aligned), mem_be, mem_wdata  : memory request
//   mem_gnt, mem_rvalid, mem_rdata                               : memory response
//   rsp_valid (one-cycle pulse), load_data (held), misalign      : completion
// Build option: define MISALIGN_TRAP_EN to complete misaligned H/HU/W
// requests immediately with misalign=1 and no memory access; otherwise
// misaligned requests are forced to alignment and misalign stays 0.
module lsu
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] alu_data,
    input  logic [31:0]       store_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    output logic [31:0]       load_data,
    output logic              misalign
);

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    lsu_state_t        state_r;
    lsu_state_t        state_s;
    logic              accept_s;
    logic              capture_s;
    logic              mem_req_s;
    logic              rsp_valid_s;

    logic [3:0]        req_be_s;
    logic [31:0]       req_wdata_s;
    logic [1:0]        req_lane_s;
    logic              trap_s;
    logic [31:0]       load_ext_s;

    logic [ADDR_W-1:0] addr_r;
    logic [2:0]        funct3_r;
    logic              is_store_r;
    logic [3:0]        be_r;
    logic [31:0]       wdata_r;
    logic [1:0]        lane_r;
    logic [31:0]       load_data_r;
    logic              misalign_r;

    lsu_align #(
        .TRAP_EN     (TRAP_EN)
    ) u_align (
        .req_funct3  (funct3),
        .req_offset  (alu_data[1:0]),
        .store_data  (store_data),
        .req_be      (req_be_s),
        .req_wdata   (req_wdata_s),
        .req_lane    (req_lane_s),
        .req_misalign(trap_s),
        .rsp_funct3  (funct3_r),
        .rsp_lane    (lane_r),
        .rdata       (mem_rdata),
        .load_ext    (load_ext_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and Moore output decode; gnt/rvalid only matter in REQ/WAIT.
    always_comb begin
        state_s     = state_r;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        mem_req_s   = 1'b0;
        rsp_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    state_s  = trap_s ? ST_RESP : ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                mem_req_s = 1'b1;
                if (mem_gnt) begin
                    state_s = is_store_r ? ST_RESP : ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    capture_s = 1'b1;
                    state_s   = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                rsp_valid_s = 1'b1;
                state_s     = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Request attributes captured on accept; they drive the memory port
    // unchanged for the whole REQ phase and steer the load extension.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r     <= {ADDR_W{1'b0}};
            funct3_r   <= 3'b000;
            is_store_r <= 1'b0;
            be_r       <= 4'b0000;
            wdata_r    <= 32'h0000_0000;
            lane_r     <= 2'b00;
        end else if (accept_s) begin
            addr_r     <= {alu_data[ADDR_W-1:2], 2'b00};
            funct3_r   <= funct3;
            is_store_r <= is_store;
            be_r       <= req_be_s;
            wdata_r    <= req_wdata_s;
            lane_r     <= req_lane_s;
        end else begin
            addr_r     <= addr_r;
            funct3_r   <= funct3_r;
            is_store_r <= is_store_r;
            be_r       <= be_r;
            wdata_r    <= wdata_r;
            lane_r     <= lane_r;
        end
    end

    // Load result: updated only by a completing load (a trapped load reads 0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_data_r <= 32'h0000_0000;
        end else if (capture_s) begin
            load_data_r <= load_ext_s;
        end else if (accept_s && trap_s && !is_store) begin
            load_data_r <= 32'h0000_0000;
        end else begin
            load_data_r <= load_data_r;
        end
    end

    // Misalign flag spans exactly the RESP cycle of a trapped request;
    // it is constant 0 when trapping is not built in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_r <= 1'b0;
        end else if (accept_s) begin
            misalign_r <= trap_s;
        end else if (state_r == ST_RESP) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= misalign_r;
        end
    end

    // req_ready is gated by rst so it reads 0 throughout reset.
    assign req_ready = (state_r == ST_IDLE) & ~rst;
    assign mem_req   = mem_req_s;
    assign mem_we    = mem_req_s & is_store_r;
    assign mem_addr  = addr_r;
    assign mem_be    = be_r;
    assign mem_wdata = wdata_r;
    assign rsp_valid = rsp_valid_s;
    assign load_data = load_data_r;
    assign misalign  = misalign_r;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu -- self-checking bench for lsu: directed vector table, reset
// corner sequences and randomized transactions against a reference model.
module tb_lsu;
    import riscv_pkg::*;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] alu_data = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] load_data;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_ld = 32'h0;

    lsu #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .is_store(is_store), .funct3(funct3), .alu_data(alu_data),
        .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .load_data(load_data), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ld;
        logic        mis;
        logic [7:0]  lat;
        logic [7:0]  rc;
        logic        we;
    } exp_t;

    typedef struct packed {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rd;
        logic [7:0]  gdly;
        logic [7:0]  rdly;
        exp_t        e;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        int          req_cycles;
        int          latency;
        logic [31:0] ld;
        logic        mis;
        int          rsp_cnt;
        logic        ready_at_accept;
        logic        ready_after;
        logic        stable;
    } obs_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Reference model: expected memory-port and completion behaviour from
    // access width, address and the memory delays.
    function automatic exp_t model(input logic st, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] sd,
                                   input logic [31:0] rd, input int gdly, input int rdly,
                                   input logic [31:0] prev_ld);
        exp_t e;
        int nbytes, off;
        bit uns, mis;
        logic [31:0] mask, v;
        case (f3)
            3'b000, 3'b100: nbytes = 1;
            3'b001, 3'b101: nbytes = 2;
            default:        nbytes = 4;
        endcase
        uns  = (f3 == 3'b100) || (f3 == 3'b101);
        off  = int'(addr % 4);
        mis  = (nbytes == 2 && (addr % 2) != 0) || (nbytes == 4 && off != 0);
        off  = off - (off % nbytes);
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
        v    = (rd >> (8 * off)) & mask;
        if (!uns && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
        e.addr  = addr - (addr % 4);
        e.be    = 4'(((1 << nbytes) - 1) << off);
        e.wdata = (nbytes == 1) ? sd[7:0] * 32'h0101_0101 :
                  (nbytes == 2) ? sd[15:0] * 32'h0001_0001 : sd;
        e.we    = st;
        if (TRAP && mis) begin
            e.lat = 8'd1; e.rc = 8'd0; e.mis = 1'b1;
            e.ld  = st ? prev_ld : 32'h0;
        end else begin
            e.rc  = 8'(gdly + 1);
            e.lat = st ? 8'(gdly + 2) : 8'(gdly + rdly + 3);
            e.mis = 1'b0;
            e.ld  = st ? prev_ld : v;
        end
        return e;
    endfunction

    // Drive one request from an IDLE cycle and play the memory side:
    // grant after gdly REQ cycles, rvalid rdly cycles into WAIT, and
    // spurious gnt/rvalid wherever they must be ignored.
    task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [31:0] rd,
                           input int gdly, input int rdly, output obs_t o);
        bit granted, delivered, seen_rsp, stop, waiting;
        int grant_cyc;
        o = '{addr: 32'h0, be: 4'h0, wdata: 32'h0, we: 1'b0, req_cycles: 0, latency: -1,
              ld: 32'h0, mis: 1'b0, rsp_cnt: 0, ready_at_accept: req_ready,
              ready_after: 1'b0, stable: 1'b1};
        req_valid = 1'b1; is_store = st; funct3 = f3; alu_data = addr; store_data = sd;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; alu_data = $urandom; store_data = $urandom;
        funct3 = 3'($urandom_range(0, 7)); is_store = 1'($urandom_range(0, 1));
        granted = 0; delivered = 0; seen_rsp = 0; stop = 0; grant_cyc = 0;
        for (int cyc = 1; cyc <= 40 && !stop; cyc++) begin
            if (seen_rsp) begin
                o.ready_after = req_ready;
                if (rsp_valid) o.rsp_cnt++;
                stop = 1;
            end else begin
                if (mem_req) begin
                    if (o.req_cycles == 0) begin
                        o.addr = mem_addr; o.be = mem_be; o.wdata = mem_wdata; o.we = mem_we;
                    end else if (o.addr !== mem_addr || o.be !== mem_be ||
                                 o.wdata !== mem_wdata || o.we !== mem_we) begin
                        o.stable = 1'b0;
                    end
                    o.req_cycles++;
                end
                if (rsp_valid) begin
                    o.rsp_cnt++; o.latency = cyc; o.ld = load_data; o.mis = misalign;
                    seen_rsp = 1;
                end
            end
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (!stop) begin
                if (mem_req && !granted) begin
                    if (o.req_cycles > gdly) begin
                        mem_gnt = 1'b1; granted = 1; grant_cyc = cyc;
                    end
                end else if (!mem_req) begin
                    mem_gnt = 1'($urandom_range(0, 1));
                end
                waiting = granted && !st && !delivered;
                if (waiting && cyc > grant_cyc) begin
                    if (cyc - grant_cyc - 1 == rdly) begin
                        mem_rvalid = 1'b1; mem_rdata = rd; delivered = 1;
                    end
                end else if (!waiting) begin
                    mem_rvalid = 1'($urandom_range(0, 1));
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic check_txn(input string tag, input obs_t o, input exp_t e);
        check({tag, " ready_at_accept"}, 32'(o.ready_at_accept), 32'd1);
        check({tag, " rsp_count"}, 32'(o.rsp_cnt), 32'd1);
        check({tag, " latency"}, 32'(o.latency), {24'h0, e.lat});
        check({tag, " req_cycles"}, 32'(o.req_cycles), {24'h0, e.rc});
        check({tag, " load_data"}, o.ld, e.ld);
        check({tag, " misalign"}, 32'(o.mis), 32'(e.mis));
        check({tag, " ready_after"}, 32'(o.ready_after), 32'd1);
        if (e.rc != 8'd0) begin
            check({tag, " mem_addr"}, o.addr, e.addr);
            check({tag, " mem_be"}, 32'(o.be), 32'(e.be));
            check({tag, " mem_we"}, 32'(o.we), 32'(e.we));
            check({tag, " stable"}, 32'(o.stable), 32'd1);
            if (e.we) check({tag, " mem_wdata"}, o.wdata, e.wdata);
        end
    endtask

    vec_t vecs[10];
    obs_t obs;
    exp_t ex;

    initial begin
        // addr, be, wdata, ld, mis, lat, rc, we
        vecs[0] = '{1'b0, F3_LW,  32'h100, 32'h0, 32'hDEADBEEF, 8'd0, 8'd0,
                    '{32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0, 8'd3, 8'd1, 1'b0}};
        vecs[1] = '{1'b0, F3_LB,  32'h103, 32'h0, 32'h80112233, 8'd0, 8'd0,
                    '{32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0, 8'd3, 8'd1, 1'b0}};
        vecs[2] = '{1'b0, F3_LBU, 32'h103, 32'h0, 32'h80112233, 8'd0, 8'd0,
                    '{32'h100, 4'b1000, 32'h0, 32'h00000080, 1'b0, 8'd3, 8'd1, 1'b0}};
        vecs[3] = '{1'b1, F3_LH,  32'h206, 32'h0000ABCD, 32'h0, 8'd3, 8'd0,
                    '{32'h204, 4'b1100, 32'hABCDABCD, 32'h00000080, 1'b0, 8'd5, 8'd4, 1'b1}};
        vecs[4] = '{1'b0, F3_LH,  32'h102, 32'h0, 32'h80017FFF, 8'd1, 8'd2,
                    '{32'h100, 4'b1100, 32'h0, 32'hFFFF8001, 1'b0, 8'd6, 8'd2, 1'b0}};
        vecs[5] = '{1'b0, F3_LHU, 32'h102, 32'h0, 32'h80017FFF, 8'd0, 8'd1,
                    '{32'h100, 4'b1100, 32'h0, 32'h00008001, 1'b0, 8'd4, 8'd1, 1'b0}};
        vecs[6] = '{1'b1, F3_LB,  32'h101, 32'h123456A5, 32'h0, 8'd0, 8'd0,
                    '{32'h100, 4'b0010, 32'hA5A5A5A5, 32'h00008001, 1'b0, 8'd2, 8'd1, 1'b1}};
        vecs[7] = '{1'b1, F3_LW,  32'h3FC, 32'hCAFEF00D, 32'h0, 8'd2, 8'd0,
                    '{32'h3FC, 4'b1111, 32'hCAFEF00D, 32'h00008001, 1'b0, 8'd4, 8'd3, 1'b1}};
        vecs[8] = '{1'b0, 3'b011, 32'h010, 32'h0, 32'h55AA55AA, 8'd0, 8'd0,
                    '{32'h010, 4'b1111, 32'h0, 32'h55AA55AA, 1'b0, 8'd3, 8'd1, 1'b0}};
`ifdef MISALIGN_TRAP_EN
        vecs[9] = '{1'b0, F3_LW,  32'h102, 32'h0, 32'h11223344, 8'd0, 8'd0,
                    '{32'h0, 4'b0000, 32'h0, 32'h00000000, 1'b1, 8'd1, 8'd0, 1'b0}};
`else
        vecs[9] = '{1'b0, F3_LW,  32'h102, 32'h0, 32'h11223344, 8'd0, 8'd0,
                    '{32'h100, 4'b1111, 32'h0, 32'h11223344, 1'b0, 8'd3, 8'd1, 1'b0}};
`endif

        // Outputs during and right after power-on reset.
        repeat (3) @(posedge clk);
        #1;
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset mem_be", 32'(mem_be), 32'd0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset load_data", load_data, 32'h0);
        check("reset misalign", 32'(misalign), 32'd0);
        rst = 1'b0;
        #1;
        check("release req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // Directed vectors, issued back to back.
        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].sd, vecs[i].rd,
                    int'(vecs[i].gdly), int'(vecs[i].rdly), obs);
            check_txn($sformatf("vec%0d", i), obs, vecs[i].e);
        end
        last_ld = vecs[9].e.ld;

        // Reset while a load sits in WAIT; the late rvalid must be dropped.
        req_valid = 1'b1; is_store = 1'b0; funct3 = F3_LW; alu_data = 32'h40;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rw mem_req", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        check("rw wait no rsp", 32'(rsp_valid), 32'd0);
        rst = 1'b1;
        #1;
        check("rw rst req_ready", 32'(req_ready), 32'd0);
        check("rw rst mem_req", 32'(mem_req), 32'd0);
        check("rw rst load_data", load_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rw release req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            check("rw no rsp", 32'(rsp_valid), 32'd0);
            check("rw ld kept", load_data, 32'h0);
        end
        last_ld = 32'h0;
        ex = model(1'b0, F3_LW, 32'h80, 32'h0, 32'h0BADF00D, 0, 1, last_ld);
        run_txn(1'b0, F3_LW, 32'h80, 32'h0, 32'h0BADF00D, 0, 1, obs);
        check_txn("post_reset_lw", obs, ex);
        last_ld = ex.ld;

        // Randomized transactions against the model.
        for (int t = 0; t < 60; t++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] addr, sd, rd;
            int          gd, rdl;
            st   = 1'($urandom_range(0, 1));
            f3   = st ? {1'b0, 2'($urandom_range(0, 2))} : 3'($urandom_range(0, 7));
            addr = $urandom; sd = $urandom; rd = $urandom;
            gd   = $urandom_range(0, 3); rdl = $urandom_range(0, 3);
            ex   = model(st, f3, addr, sd, rd, gd, rdl, last_ld);
            run_txn(st, f3, addr, sd, rd, gd, rdl, obs);
            check_txn($sformatf("rnd%0d", t), obs, ex);
            last_ld = ex.ld;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
